// File: rtl/tt_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tt_sweep_ctrl
//   Truth-table sweep sequencer for one combinational NOT/NOR gate netlist.
//   Drives every input vector 0..2**N_IN-1 into the gate, waits SETTLE_CYCLES
//   per vector, samples the gate output, assembles the captured truth table
//   and compares it with an expected word captured at start.
//
// Parameters
//   N_IN           gate input count (1..6); table width TT_W = 2**N_IN
//   SETTLE_CYCLES  wait cycles per vector before sampling (0..255)
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start_i     in   sweep request, accepted only in IDLE
//   expected_i  in   expected truth table, captured on accept
//   gate_in_o   out  vector driven to the gate
//   gate_out_i  in   gate output
//   busy_o      out  high from the cycle after accept until done_o
//   done_o      out  one-cycle completion pulse
//   tt_o        out  captured table, bit i = gate output for vector i
//   match_o     out  tt_o == captured expected, valid with done_o, held after
//   err_cnt_o   out  (TT_SWEEP_ERRCNT_EN only) count of mismatching rows
//
// Configuration macro: TT_SWEEP_ERRCNT_EN adds err_cnt_o and its counter.
// ----------------------------------------------------------------------------
module tt_sweep_ctrl #(
  parameter int unsigned N_IN          = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2**N_IN-1:0]   expected_i,
  output logic [N_IN-1:0]      gate_in_o,
  input  logic                 gate_out_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2**N_IN-1:0]   tt_o,
  output logic                 match_o
`ifdef TT_SWEEP_ERRCNT_EN
  ,
  output logic [N_IN:0]        err_cnt_o
`endif
);

  localparam int unsigned TT_W          = 2**N_IN;
  localparam bit          LP_HAS_SETTLE = (SETTLE_CYCLES > 0);
  localparam logic [7:0]  LP_CNT_LAST   = LP_HAS_SETTLE ? 8'(SETTLE_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [N_IN-1:0]   r_vec;
  logic [7:0]        r_cnt;
  logic [TT_W-1:0]   r_exp;
  logic [TT_W-1:0]   r_tt;
  logic              r_busy;
  logic              r_done;
  logic              r_match;

  logic [TT_W-1:0]   w_tt_next;
  logic              w_last_vec;
  logic              w_cnt_last;

  // Table including the bit being sampled this cycle, so match_o can be
  // registered on the same edge that enters DONE and be valid with done_o.
  always_comb begin
    w_tt_next        = r_tt;
    w_tt_next[r_vec] = gate_out_i;
    w_last_vec       = (r_vec == '1);
    w_cnt_last       = (r_cnt == LP_CNT_LAST);
  end

`ifdef TT_SWEEP_ERRCNT_EN
  logic [N_IN:0]     r_err;
  logic              w_miss;

  always_comb begin
    w_miss = gate_out_i ^ r_exp[r_vec];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else if (r_state == S_IDLE && start_i) begin
      r_err <= '0;
    end else if (r_state == S_SAMPLE) begin
      r_err <= r_err + {{N_IN{1'b0}}, w_miss};
    end
  end

  assign err_cnt_o = r_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_tt    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_exp   <= expected_i;
            r_tt    <= '0;
            r_match <= 1'b0;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= LP_HAS_SETTLE ? S_SETTLE : S_SAMPLE;
          end
        end

        S_SETTLE: begin
          if (w_cnt_last) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_SAMPLE: begin
          r_tt <= w_tt_next;
          if (w_last_vec) begin
            // Vector counter is not incremented here, so gate_in_o holds TT_W-1.
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_match <= (w_tt_next == r_exp);
          end else begin
            r_vec   <= r_vec + 1'b1;
            r_cnt   <= '0;
            r_state <= LP_HAS_SETTLE ? S_SETTLE : S_SAMPLE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gate_in_o = r_vec;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign tt_o      = r_tt;
  assign match_o   = r_match;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: stimulus pushes expected sweep results into a
// queue, a monitor per DUT pops and compares on each done_o pulse.
// dut0: default parameters (settle 4); dut1: settle 0.
module tb_tt_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] exp0 = '0, exp1 = '0;
  logic [3:0]  gi0, gi1;
  logic        go0, go1;
  logic        busy0, busy1, done0, done1, match0, match1;
  logic [15:0] tt0, tt1;
  logic [4:0]  err0, err1;
  logic [1:0]  mode0 = 2'd0;
  logic [15:0] fn_c4b2 = 16'hC4B2;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned cyc    = 0;

  typedef struct {
    logic [15:0] tt;
    logic        match;
    logic [4:0]  err;
    int unsigned start;
    int unsigned lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .expected_i(exp0),
    .gate_in_o(gi0), .gate_out_i(go0), .busy_o(busy0), .done_o(done0),
    .tt_o(tt0), .match_o(match0)
`ifdef TT_SWEEP_ERRCNT_EN
    , .err_cnt_o(err0)
`endif
  );

  tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .expected_i(exp1),
    .gate_in_o(gi1), .gate_out_i(go1), .busy_o(busy1), .done_o(done1),
    .tt_o(tt1), .match_o(match1)
`ifdef TT_SWEEP_ERRCNT_EN
    , .err_cnt_o(err1)
`endif
  );

`ifndef TT_SWEEP_ERRCNT_EN
  assign err0 = '0;
  assign err1 = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate models attached to the sequencers.
  always_comb begin
    case (mode0)
      2'd0:    go0 = gi0[0];
      2'd1:    go0 = gi0[3];
      2'd2:    go0 = fn_c4b2[gi0];
      default: go0 = 1'b0;
    endcase
    go1 = gi1[1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitors: compare on every done pulse.
  logic prev_done0 = 1'b0, prev_done1 = 1'b0;

  always @(negedge clk) begin
    if (!rst && done0) begin
      check("dut0_done_width", {31'd0, prev_done0}, 32'd0);
      if (q0.size() == 0) begin
        check("dut0_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0_tt", {16'd0, tt0}, {16'd0, e.tt});
        check("dut0_match", {31'd0, match0}, {31'd0, e.match});
        check("dut0_latency", cyc - e.start, e.lat);
        check("dut0_busy_low_at_done", {31'd0, busy0}, 32'd0);
        check("dut0_last_vec", {28'd0, gi0}, 32'hF);
`ifdef TT_SWEEP_ERRCNT_EN
        check("dut0_err_cnt", {27'd0, err0}, {27'd0, e.err});
`endif
      end
    end
    prev_done0 = done0;
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      check("dut1_done_width", {31'd0, prev_done1}, 32'd0);
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1_tt", {16'd0, tt1}, {16'd0, e.tt});
        check("dut1_match", {31'd0, match1}, {31'd0, e.match});
        check("dut1_latency", cyc - e.start, e.lat);
`ifdef TT_SWEEP_ERRCNT_EN
        check("dut1_err_cnt", {27'd0, err1}, {27'd0, e.err});
`endif
      end
    end
    prev_done1 = done1;
  end

  // Issue a single-cycle start on dut0; expected_i is scrambled right after
  // acceptance to show it no longer matters.
  task automatic sweep0(input logic [1:0] m, input logic [15:0] expv,
                        input logic [15:0] tt, input logic mt, input logic [4:0] e);
    exp_t x;
    @(negedge clk);
    mode0  = m;
    exp0   = expv;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    exp0   = ~expv;
    x = '{tt: tt, match: mt, err: e, start: cyc, lat: 80};
    q0.push_back(x);
    check("dut0_busy_after_start", {31'd0, busy0}, 32'd1);
  endtask

  task automatic drain0(input string name);
    for (int i = 0; i < 400 && q0.size() != 0; i++) @(negedge clk);
    check(name, q0.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    exp_t x;
    // Reset state
    #1;
    check("rst_gate_in", {28'd0, gi0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_tt", {16'd0, tt0}, 32'd0);
    check("rst_match", {31'd0, match0}, 32'd0);
    check("rst_err", {27'd0, err0}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: identity on input 0
    sweep0(2'd0, 16'hAAAA, 16'hAAAA, 1'b1, 5'd0);
    drain0("t1_done");
    // 2: input 3 against C4B2 (C4B2 ^ FF00 = 3BB2, 9 rows differ)
    sweep0(2'd1, 16'hC4B2, 16'hFF00, 1'b0, 5'd9);
    drain0("t2_done");
    check("t2_tt_held", {16'd0, tt0}, 32'h0000FF00);
    // 3: gate implementing C4B2
    sweep0(2'd2, 16'hC4B2, 16'hC4B2, 1'b1, 5'd0);
    drain0("t3_done");
    // 4: constant 0 gate
    sweep0(2'd3, 16'hC4B2, 16'h0000, 1'b0, 5'd7);
    drain0("t4_done");

    // 5: async reset mid-sweep
    sweep0(2'd0, 16'hAAAA, 16'hAAAA, 1'b1, 5'd0);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_gate_in", {28'd0, gi0}, 32'd0);
    check("t5_busy", {31'd0, busy0}, 32'd0);
    check("t5_tt", {16'd0, tt0}, 32'd0);
    check("t5_match", {31'd0, match0}, 32'd0);
    check("t5_err", {27'd0, err0}, 32'd0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sweep0(2'd1, 16'hFF00, 16'hFF00, 1'b1, 5'd0);
    drain0("t5_full_sweep_done");

    // 6a: extra start pulses mid-sweep are ignored
    sweep0(2'd0, 16'h5555, 16'hAAAA, 1'b0, 5'd16);
    repeat (8) @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    repeat (39) @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    drain0("t6_single_done");
    repeat (100) @(negedge clk);
    check("t6_no_extra_sweep", {31'd0, busy0}, 32'd0);

    // 6b: held start re-arms on the IDLE cycle after DONE
    @(negedge clk);
    mode0  = 2'd2;
    exp0   = 16'hC4B2;
    start0 = 1'b1;
    @(negedge clk);
    x = '{tt: 16'hC4B2, match: 1'b1, err: 5'd0, start: cyc, lat: 80};
    q0.push_back(x);
    x.start = cyc + 82;
    q0.push_back(x);
    repeat (82) @(negedge clk);
    start0 = 1'b0;
    check("t6_rearm_busy", {31'd0, busy0}, 32'd1);
    drain0("t6_rearm_done");

    // 6c: SETTLE_CYCLES=0 build, 16-edge sweep, extra pulse ignored
    @(negedge clk);
    exp1   = 16'hCCCC;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    exp1   = 16'h0000;
    x = '{tt: 16'hCCCC, match: 1'b1, err: 5'd0, start: cyc, lat: 16};
    q1.push_back(x);
    repeat (7) @(negedge clk);
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 100 && q1.size() != 0; i++) @(negedge clk);
    check("t6c_done", q1.size(), 0);
    repeat (30) @(negedge clk);
    check("t6c_no_extra_sweep", {31'd0, busy1}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
